dram_port_sched: RTL
====================

DRAM_PORT_SCHED -- requirements
Module: dram_port_sched

Interface
REQ-001 Parameter ADDR_W, default 27, SHALL set the DRAM word-address width.
REQ-002 Parameter TIMEOUT, default 4096, SHALL set the maximum number of WAIT cycles before a transaction is aborted.
REQ-003 clk  input  1  SHALL be the single clock; all logic is on its rising edge.
REQ-004 rst_async  input  1  SHALL be the reset: asynchronous, active-high.
REQ-005 ld_req, ld_addr[ADDR_W], ld_wdata[32]  input  SHALL form the loader request; it is write-only with a full-word write.
REQ-006 ld_done  output  1  SHALL pulse to complete a loader transaction.
REQ-007 ic_req, ic_addr[ADDR_W]  input  SHALL form the instruction-cache request; it is read-only.
REQ-008 ic_rdata[32], ic_done  output  SHALL return the instruction-cache read result.
REQ-009 dc_req, dc_addr[ADDR_W], dc_wdata[32], dc_we[4]  input  SHALL form the data-cache request; dc_we==0 means read.
REQ-010 dc_rdata[32], dc_done  output  SHALL return the data-cache result.
REQ-011 dram_oe  output  1; dram_addr  output  ADDR_W; dram_wdata  output  32; dram_we  output  4  SHALL form the DRAM command.
REQ-012 dram_rdata  input  32; dram_valid  input  1; dram_written  input  1  SHALL form the DRAM completion.
REQ-013 err  output  1  SHALL be a sticky protocol/timeout flag.

Function
REQ-014 The FSM SHALL have states IDLE, ISSUE, WAIT and RESP, with at most one DRAM transaction outstanding.
REQ-015 A requester SHALL hold req high, with its address and data stable, until its done pulse, and SHALL drop req in the cycle after done.
REQ-016 In IDLE, arbitration SHALL apply these priorities:
- ld_req has absolute priority.
- Between ic and dc, round-robin: the one not granted most recently wins a tie.
- After reset, dc is treated as last-granted, so ic wins the first tie.
REQ-017 On a grant in IDLE, at the next edge the block SHALL:
- latch the owner, address, wdata and we;
- enter ISSUE.
REQ-018 The latched we SHALL be: 4'hF for the loader, 4'h0 for ic, dc_we for dc.
REQ-019 In ISSUE, dram_oe SHALL be 1 for exactly one cycle, with dram_addr/wdata/we driven from the latches; the next state SHALL be WAIT.
REQ-020 dram_addr/wdata/we SHALL hold their latched values through WAIT.
REQ-021 Completion SHALL be dram_valid for a read (we==0) or dram_written for a write (we!=0); it is accepted in ISSUE or WAIT and moves the FSM to RESP.
REQ-022 In RESP, exactly one cycle, the owner's done SHALL be 1 and the FSM SHALL then return to IDLE.
REQ-023 ic_rdata/dc_rdata SHALL hold the dram_rdata captured at completion and remain stable until the next completion for that owner.
REQ-024 RESP SHALL NOT arbitrate, so a req still high during done is never re-granted.
REQ-025 Minimum latency: req high in IDLE at cycle t gives dram_oe at t+1; completion at cycle c gives done at c+1.
REQ-026 A WAIT cycle counter SHALL clear on entry to WAIT and, on reaching TIMEOUT-1 without completion, SHALL:
- set err;
- enter RESP with rdata 32'hDEADBEEF.
REQ-027 Any dram_valid or dram_written in IDLE or RESP, or a completion of the wrong kind, SHALL set err and be otherwise ignored.
REQ-028 err SHALL clear only on reset.
REQ-029 A requester dropping req mid-transaction SHALL not abort the transaction; done is still pulsed.

Reset
REQ-030 While rst_async is high, the block SHALL hold:
- state IDLE;
- dram_oe, all done outputs and err at 0;
- dram_addr, dram_wdata, dram_we, ic_rdata and dc_rdata at 0;
- round-robin pointer = dc;
- timeout counter 0.
REQ-031 Reset asserted mid-transaction SHALL abandon the transaction with no done pulse, and late DRAM completions after deassertion SHALL set err.
REQ-032 The first grant SHALL be possible in the first cycle after rst_async deasserts.

Verification
REQ-033 The bench SHALL cover the following directed scenarios:
- Single ic read, addr 0x100, DRAM returns 0x12345678 three cycles after dram_oe: dram_oe one cycle with we=0, then ic_done one cycle after dram_valid with ic_rdata=0x12345678.
- ic, dc and ld requests rise in the same cycle: grant order ld, ic, dc; a persistent ic/dc pair then alternates; no two done outputs are ever high together.
- dc write we=4'b0011, data 0xAABBCCDD: dram_we=4'b0011, dram_wdata=0xAABBCCDD; completion only on dram_written, and a dram_valid arriving in WAIT sets err.
- TIMEOUT=16 with no DRAM completion: done at WAIT cycle 16 with rdata 0xDEADBEEF, err=1 held until reset.
- rst_async pulsed while in WAIT: outputs return to reset values immediately; a later dram_valid sets err; a new ic request is serviced normally.
- Completion coincident with the ISSUE cycle: accepted, done on the next cycle.

Source files
------------

// File: rtl/dram_port_sched.sv
// Single-outstanding DRAM port scheduler: loader (absolute priority) plus
// round-robin instruction/data cache requesters sharing one DRAM command port.
module dram_port_sched #(
   parameter int ADDR_W  = 27,
   parameter int TIMEOUT = 4096
) (
   input  logic              clk,
   input  logic              rst_async,
   input  logic              ld_req,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [31:0]       ld_wdata,
   output logic              ld_done,
   input  logic              ic_req,
   input  logic [ADDR_W-1:0] ic_addr,
   output logic [31:0]       ic_rdata,
   output logic              ic_done,
   input  logic              dc_req,
   input  logic [ADDR_W-1:0] dc_addr,
   input  logic [31:0]       dc_wdata,
   input  logic [3:0]        dc_we,
   output logic [31:0]       dc_rdata,
   output logic              dc_done,
   output logic              dram_oe,
   output logic [ADDR_W-1:0] dram_addr,
   output logic [31:0]       dram_wdata,
   output logic [3:0]        dram_we,
   input  logic [31:0]       dram_rdata,
   input  logic              dram_valid,
   input  logic              dram_written,
   output logic              err
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;
   typedef enum logic [1:0] {OWN_LD, OWN_IC, OWN_DC} owner_t;

   state_t             state_q, state_d;
   owner_t             owner_q, owner_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [31:0]        wdata_q, wdata_d;
   logic [3:0]         we_q, we_d;
   logic               dc_last_q, dc_last_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               err_q, err_d;
   logic [31:0]        ic_rdata_q, ic_rdata_d;
   logic [31:0]        dc_rdata_q, dc_rdata_d;

   logic               is_read;
   logic               cpl_ok;
   logic               cpl_bad;
   logic               pick_ic;

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      we_d       = we_q;
      dc_last_d  = dc_last_q;
      cnt_d      = cnt_q;
      err_d      = err_q;
      ic_rdata_d = ic_rdata_q;
      dc_rdata_d = dc_rdata_q;

      is_read = (we_q == 4'h0);
      cpl_ok  = is_read ? dram_valid   : dram_written;
      cpl_bad = is_read ? dram_written : dram_valid;
      // On a tie, ic wins only if dc was the most recent cache grant.
      pick_ic = ic_req && (!dc_req || dc_last_q);

      case (state_q)
         S_IDLE: begin
            if (dram_valid || dram_written) err_d = 1'b1;
            if (ld_req) begin
               state_d = S_ISSUE;
               owner_d = OWN_LD;
               addr_d  = ld_addr;
               wdata_d = ld_wdata;
               we_d    = 4'hF;
            end else if (pick_ic) begin
               state_d   = S_ISSUE;
               owner_d   = OWN_IC;
               addr_d    = ic_addr;
               wdata_d   = 32'h0;
               we_d      = 4'h0;
               dc_last_d = 1'b0;
            end else if (dc_req) begin
               state_d   = S_ISSUE;
               owner_d   = OWN_DC;
               addr_d    = dc_addr;
               wdata_d   = dc_wdata;
               we_d      = dc_we;
               dc_last_d = 1'b1;
            end
         end
         S_ISSUE, S_WAIT: begin
            if (cpl_bad) err_d = 1'b1;
            if (cpl_ok) begin
               state_d = S_RESP;
               if (is_read && owner_q == OWN_IC) ic_rdata_d = dram_rdata;
               if (is_read && owner_q == OWN_DC) dc_rdata_d = dram_rdata;
            end else if (state_q == S_ISSUE) begin
               state_d = S_WAIT;
               cnt_d   = '0;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               // Timed out: release the requester with a poison word.
               state_d = S_RESP;
               err_d   = 1'b1;
               if (owner_q == OWN_IC) ic_rdata_d = 32'hDEADBEEF;
               if (owner_q == OWN_DC) dc_rdata_d = 32'hDEADBEEF;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_RESP: begin
            if (dram_valid || dram_written) err_d = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst_async) begin
      if (rst_async) begin
         state_q    <= S_IDLE;
         owner_q    <= OWN_LD;
         addr_q     <= '0;
         wdata_q    <= '0;
         we_q       <= '0;
         dc_last_q  <= 1'b1;
         cnt_q      <= '0;
         err_q      <= 1'b0;
         ic_rdata_q <= '0;
         dc_rdata_q <= '0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         we_q       <= we_d;
         dc_last_q  <= dc_last_d;
         cnt_q      <= cnt_d;
         err_q      <= err_d;
         ic_rdata_q <= ic_rdata_d;
         dc_rdata_q <= dc_rdata_d;
      end
   end

   assign dram_oe    = (state_q == S_ISSUE);
   assign dram_addr  = addr_q;
   assign dram_wdata = wdata_q;
   assign dram_we    = we_q;
   assign ld_done    = (state_q == S_RESP) && (owner_q == OWN_LD);
   assign ic_done    = (state_q == S_RESP) && (owner_q == OWN_IC);
   assign dc_done    = (state_q == S_RESP) && (owner_q == OWN_DC);
   assign ic_rdata   = ic_rdata_q;
   assign dc_rdata   = dc_rdata_q;
   assign err        = err_q;

endmodule
